// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, parameter
// defaults and a one-hot to index helper.
package uart_sched_pkg;

  localparam int DEFAULT_NUM_REQ      = 2;
  localparam int DEFAULT_BUSY_TIMEOUT = 1024;
  localparam int DEFAULT_TO_W         = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } sched_state_t;

  function automatic int onehot_to_idx(input logic [7:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side byte stream bundle: one valid/data/last/ready lane per requester.
interface uart_tx_scheduler_if
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, output req_last, input req_ready);
  modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler_arb.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);
  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ requesters, granting whole messages
// round-robin and sequencing each byte through start / busy / done.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ      = DEFAULT_NUM_REQ,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT,
  parameter int TO_W         = DEFAULT_TO_W
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_scheduler_if.slave  req,
  output logic                uart_start,
  output logic [7:0]          uart_data,
  input  logic                uart_tx_done,
  output logic [NUM_REQ-1:0]  grant,
  output logic                msg_done,
  output logic                err_timeout
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t       state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [PTR_W-1:0]   gidx_reg, gidx_next;
  logic [PTR_W-1:0]   rr_reg, rr_next;
  logic [TO_W-1:0]    cnt_reg, cnt_next;
  logic [7:0]         data_reg, data_next;
  logic               last_reg, last_next;
  logic               start_reg;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] ready_vec;
  logic [PTR_W-1:0]   gidx_inc;
  logic [7:0]         req_bytes [NUM_REQ];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req   (req.req_valid),
    .ptr   (rr_reg),
    .grant (arb_grant)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign req_bytes[gi]     = req.req_data[8*gi +: 8];
    assign req.req_ready[gi] = ready_vec[gi];
  end

  assign gidx_inc = (gidx_reg == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_reg + 1'b1;

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    gidx_next   = gidx_reg;
    rr_next     = rr_reg;
    cnt_next    = cnt_reg;
    data_next   = data_reg;
    last_next   = last_reg;
    ready_vec   = '0;
    msg_done    = 1'b0;
    err_timeout = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A busy UART may still be finishing a frame from before reset: do not arbitrate.
        if (uart_tx_done && (|req.req_valid)) begin
          grant_next = arb_grant;
          gidx_next  = PTR_W'(onehot_to_idx(8'(arb_grant)));
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ready_vec = grant_reg & req.req_valid;
        if (|ready_vec) begin
          data_next  = req_bytes[gidx_reg];
          last_next  = req.req_last[gidx_reg];
          state_next = ST_START;
        end
      end
      ST_START: begin
        cnt_next   = '0;
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!uart_tx_done) begin
          state_next = ST_WAIT_DONE;
        end else if (cnt_reg == TO_W'(BUSY_TIMEOUT)) begin
          err_timeout = 1'b1;
          grant_next  = '0;
          rr_next     = gidx_inc;
          state_next  = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (uart_tx_done) begin
          if (last_reg) begin
            msg_done   = 1'b1;
            grant_next = '0;
            rr_next    = gidx_inc;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      gidx_reg  <= '0;
      rr_reg    <= '0;
      cnt_reg   <= '0;
      data_reg  <= 8'h00;
      last_reg  <= 1'b0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      gidx_reg  <= gidx_next;
      rr_reg    <= rr_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
      // Registered so the UART sees a glitch-free start edge.
      start_reg <= (state_next == ST_START);
    end
  end

  assign uart_start = start_reg;
  assign uart_data  = data_reg;
  assign grant      = grant_reg;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: behavioural UART (16 clk/bit), requester drivers,
// and a message-level round-robin model checked every cycle.
module tb_uart_tx_scheduler;
  localparam int NR = 2;
  localparam int BT = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_start;
  logic [7:0] uart_data;
  logic       uart_tx_done;
  logic [1:0] grant;
  logic       msg_done;
  logic       err_timeout;

  uart_tx_scheduler_if #(.NUM_REQ(NR)) rif ();

  uart_tx_scheduler #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT), .TO_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (rif),
    .uart_start   (uart_start),
    .uart_data    (uart_data),
    .uart_tx_done (uart_tx_done),
    .grant        (grant),
    .msg_done     (msg_done),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural UART: 10-bit frame of 16 clocks per bit, data sampled mid-bit.
  logic       stuck = 1'b0;
  logic       u_tx = 1'b1;
  logic       u_busy = 1'b0;
  logic       u_prev_start = 1'b0;
  int         u_t = 0;
  logic [7:0] u_sh = 8'h00;
  logic [7:0] line_byte = 8'h00;

  assign uart_tx_done = stuck | u_tx;

  always @(posedge clk) begin
    u_prev_start <= uart_start;
    if (!u_busy) begin
      if (uart_start && !u_prev_start && !stuck) begin
        u_busy <= 1'b1;
        u_tx   <= 1'b0;
        u_t    <= 0;
      end
    end else begin
      u_t <= u_t + 1;
      for (int k = 1; k <= 8; k++) begin
        if (u_t == 16*k + 8) u_sh[k-1] <= uart_data[k-1];
      end
      if (u_t == 159) begin
        u_busy    <= 1'b0;
        u_tx      <= 1'b1;
        line_byte <= u_sh;
      end
    end
  end

  // Stimulus store (driver side) and expectation store (model side).
  logic [8:0] src_mem [NR][64];
  int         src_gap [NR][64];
  int         src_rd [NR];
  int         src_wr [NR];
  logic [8:0] exp_mem [NR][64];
  int         exp_rd [NR];
  int         exp_wr [NR];

  task automatic push(input int r, input logic [7:0] d, input logic lst, input int gap);
    src_mem[r][src_wr[r]] = {lst, d};
    src_gap[r][src_wr[r]] = gap;
    src_wr[r]++;
    exp_mem[r][exp_wr[r]] = {lst, d};
    exp_wr[r]++;
  endtask

  initial begin
    logic hs [NR];
    logic loaded [NR];
    int   gapc [NR];
    logic [8:0] item;
    rif.req_valid = '0;
    rif.req_data  = '0;
    rif.req_last  = '0;
    for (int i = 0; i < NR; i++) begin
      src_rd[i] = 0; src_wr[i] = 0; exp_rd[i] = 0; exp_wr[i] = 0;
      loaded[i] = 1'b0; gapc[i] = 0; hs[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) hs[i] = rif.req_valid[i] & rif.req_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          src_rd[i]++;
          loaded[i] = 1'b0;
        end
        if (src_rd[i] != src_wr[i]) begin
          if (!loaded[i]) begin
            gapc[i]   = src_gap[i][src_rd[i]];
            loaded[i] = 1'b1;
          end
          if (gapc[i] > 0) begin
            gapc[i]--;
            rif.req_valid[i] = 1'b0;
          end else begin
            item = src_mem[i][src_rd[i]];
            rif.req_valid[i]      = 1'b1;
            rif.req_data[8*i +: 8] = item[7:0];
            rif.req_last[i]       = item[8];
          end
        end else begin
          rif.req_valid[i] = 1'b0;
          loaded[i]        = 1'b0;
        end
      end
    end
  end

  function automatic int pick(input int ptr, input logic [1:0] v);
    for (int off = 0; off < NR; off++) begin
      if (v[(ptr + off) % NR]) return (ptr + off) % NR;
    end
    return -1;
  endfunction

  // Model state and observation counters.
  int         cyc = 0;
  int         model_ptr = 0;
  int         model_g = -1;
  int         hs_pending = 0;
  int         last_start_cyc = -100;
  int         n_line = 0, n_msg = 0, n_start = 0, n_err = 0;
  int         err_delta = -1;
  int         line_log [64];
  logic       ignore_line = 1'b0;
  logic [1:0] grant_or = 2'b00;

  initial begin
    logic       prev_tx;
    logic [1:0] prev_grant;
    logic [1:0] prev_valid;
    logic       prev_msg, prev_err;
    logic       exp_msg, exp_err;
    logic [8:0] e;
    int         p;
    prev_tx = 1'b1; prev_grant = '0; prev_valid = '0; prev_msg = 1'b0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("rst_req_ready", rif.req_ready, 0);
        chk("rst_uart_start", uart_start, 0);
        chk("rst_uart_data", uart_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_msg_done", msg_done, 0);
        chk("rst_err_timeout", err_timeout, 0);
        model_ptr = 0; model_g = -1; hs_pending = 0;
        prev_grant = '0; prev_msg = 1'b0; prev_err = 1'b0;
      end else begin
        chk("grant_onehot", ($countones(grant) <= 1), 1);
        chk("ready_in_grant", rif.req_ready & ~grant, 0);
        if (prev_msg || prev_err) begin
          chk("grant_release", grant, 0);
        end else if (prev_grant == 0 && grant != 0) begin
          p = pick(model_ptr, prev_valid);
          chk("arb_when_idle", prev_tx, 1);
          chk("arb_pick", grant, (p < 0) ? 0 : (1 << p));
          model_g = p;
        end else if (prev_grant != 0) begin
          chk("grant_hold", grant, prev_grant);
        end
        grant_or |= grant;
        if (|(rif.req_valid & rif.req_ready)) hs_pending++;
        if (uart_start) begin
          chk("start_gap", (cyc - last_start_cyc >= 3), 1);
          chk("start_after_hs", hs_pending, 1);
          hs_pending = 0;
          last_start_cyc = cyc;
          n_start++;
        end
        exp_msg = 1'b0;
        exp_err = 1'b0;
        if (uart_tx_done && !prev_tx) begin
          if (ignore_line) begin
            ignore_line = 1'b0;
          end else if (model_g < 0) begin
            chk("line_owner", 0, 1);
          end else begin
            e = exp_mem[model_g][exp_rd[model_g]];
            exp_rd[model_g]++;
            chk("line_byte", line_byte, e[7:0]);
            $display("line byte %02h from req %0d last=%0d", line_byte, model_g, e[8]);
            line_log[n_line] = int'(line_byte);
            n_line++;
            exp_msg = e[8];
          end
        end
        if (stuck && model_g >= 0 && (cyc - last_start_cyc == BT + 1)) begin
          exp_err = 1'b1;
          exp_rd[model_g]++;
        end
        chk("msg_done", msg_done, exp_msg);
        chk("err_timeout", err_timeout, exp_err);
        if (err_timeout) err_delta = cyc - last_start_cyc;
        if (exp_msg || exp_err) begin
          model_ptr = (model_g + 1) % NR;
          model_g = -1;
          if (exp_msg) n_msg++;
          if (exp_err) n_err++;
        end
        prev_grant = grant;
        prev_msg = msg_done;
        prev_err = err_timeout;
      end
      prev_tx = uart_tx_done;
      prev_valid = rif.req_valid;
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    int quiet;
    n = 0;
    quiet = 0;
    while (quiet < 4 && n < 4000) begin
      @(negedge clk);
      n++;
      if (src_rd[0] == src_wr[0] && src_rd[1] == src_wr[1] && grant == 0 && uart_tx_done && !u_busy)
        quiet++;
      else
        quiet = 0;
    end
    if (quiet < 4) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int b_line, b_msg, b_start, b_err;

  task automatic mark();
    b_line = n_line; b_msg = n_msg; b_start = n_start; b_err = n_err;
    grant_or = 2'b00;
  endtask

  initial begin
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(2);

    // Both requesters valid at reset exit: req0 message, then req1.
    mark();
    push(0, 8'h11, 1'b0, 0); push(0, 8'h12, 1'b1, 0);
    push(1, 8'h21, 1'b0, 0); push(1, 8'h22, 1'b1, 0);
    wait_idle("t_both");
    chk("t_both_l0", line_log[b_line + 0], 'h11);
    chk("t_both_l1", line_log[b_line + 1], 'h12);
    chk("t_both_l2", line_log[b_line + 2], 'h21);
    chk("t_both_l3", line_log[b_line + 3], 'h22);
    chk("t_both_starts", n_start - b_start, 4);
    chk("t_both_msgs", n_msg - b_msg, 2);

    // Single two-byte message from req0.
    mark();
    push(0, 8'hA5, 1'b0, 0); push(0, 8'h3C, 1'b1, 0);
    wait_idle("t_two");
    chk("t_two_l0", line_log[b_line + 0], 'hA5);
    chk("t_two_l1", line_log[b_line + 1], 'h3C);
    chk("t_two_starts", n_start - b_start, 2);
    chk("t_two_msgs", n_msg - b_msg, 1);
    chk("t_two_grant", grant_or, 2'b01);

    // Req1 stalls 50 cycles mid-message while req0 waits.
    mark();
    push(1, 8'h31, 1'b0, 0); push(1, 8'h32, 1'b1, 50);
    push(0, 8'h41, 1'b1, 0);
    wait_idle("t_stall");
    chk("t_stall_l0", line_log[b_line + 0], 'h31);
    chk("t_stall_l1", line_log[b_line + 1], 'h32);
    chk("t_stall_l2", line_log[b_line + 2], 'h41);
    chk("t_stall_starts", n_start - b_start, 3);

    // Three single-byte messages from req0; pointer wraps past idle req1.
    mark();
    push(0, 8'h51, 1'b1, 0); push(0, 8'h52, 1'b1, 0); push(0, 8'h53, 1'b1, 0);
    wait_idle("t_b2b");
    chk("t_b2b_l0", line_log[b_line + 0], 'h51);
    chk("t_b2b_l1", line_log[b_line + 1], 'h52);
    chk("t_b2b_l2", line_log[b_line + 2], 'h53);
    chk("t_b2b_msgs", n_msg - b_msg, 3);
    chk("t_b2b_grant", grant_or, 2'b01);

    // Reset during WAIT_DONE, then a fresh message from req1.
    mark();
    push(0, 8'h61, 1'b0, 0); push(0, 8'h62, 1'b1, 0);
    begin
      int n;
      n = 0;
      while (n_start == b_start && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("t_rst_started", (n_start > b_start), 1);
    end
    wait_cycles(20);
    reset = 1'b1;
    for (int i = 0; i < NR; i++) begin
      src_rd[i] = src_wr[i];
      exp_rd[i] = exp_wr[i];
    end
    ignore_line = 1'b1;
    #1;
    chk("t_rst_now_start", uart_start, 0);
    chk("t_rst_now_data", uart_data, 0);
    chk("t_rst_now_grant", grant, 0);
    chk("t_rst_now_ready", rif.req_ready, 0);
    chk("t_rst_now_msg", msg_done, 0);
    chk("t_rst_now_err", err_timeout, 0);
    wait_cycles(3);
    reset = 1'b0;
    mark();
    push(1, 8'h71, 1'b0, 0); push(1, 8'h72, 1'b1, 0);
    wait_idle("t_rst");
    chk("t_rst_l0", line_log[b_line + 0], 'h71);
    chk("t_rst_l1", line_log[b_line + 1], 'h72);
    chk("t_rst_grant", grant_or, 2'b10);

    // UART never goes busy: abort after BUSY_TIMEOUT.
    stuck = 1'b1;
    mark();
    push(0, 8'h81, 1'b1, 0);
    wait_idle("t_to");
    chk("t_to_errs", n_err - b_err, 1);
    chk("t_to_delta", err_delta, 21);
    chk("t_to_lines", n_line - b_line, 0);
    chk("t_to_grant_clear", grant, 0);
    stuck = 1'b0;
    wait_cycles(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
